id_ex_pipe_reg: RTL and testbench
=================================

Name: id_ex_pipe_reg

Overview:
- Parametrised decode→execute pipeline register with a valid/ready handshake and a 2-entry skid buffer (main + skid).
- Adds synchronous flush and a writeback bypass, so held operands never go stale during a stall.
- Provides a saturating stall-cycle counter for performance monitoring.
- Sits between the decode stage (register read, immediate generation, control unit) and the execute stage (ALU).

Parameters:
XLEN, 32, width of pc, rs1_data, rs2_data, imm, wb_data
RADDR_W, 5, register address width (rs1, rs2, rd, wb_rd)
ALU_OP_W, 4, ALU opcode width
CTRL_W, 8, control-unit signal bundle width
CNT_W, 16, stall counter width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  decode presents an instruction
in_ready  output  1  block can accept; registered, equals !skid_valid
in_pc  input  XLEN  instruction PC
in_rs1  input  RADDR_W  source register 1 address
in_rs2  input  RADDR_W  source register 2 address
in_rs1_data  input  XLEN  source 1 operand
in_rs2_data  input  XLEN  source 2 operand
in_imm  input  XLEN  immediate
in_rd  input  RADDR_W  destination register
in_alu_op  input  ALU_OP_W  ALU operation
in_ctrl  input  CTRL_W  control-unit signals
flush  input  1  kill all held and incoming instructions
wb_en  input  1  writeback stage writes register file this cycle
wb_rd  input  RADDR_W  writeback destination
wb_data  input  XLEN  writeback value
out_valid  output  1  main entry valid
out_ready  input  1  execute accepts
out_pc, out_rs1, out_rs2, out_rs1_data, out_rs2_data, out_imm, out_rd, out_alu_op, out_ctrl  output  (widths as inputs)  main entry fields
stall_cycles  output  CNT_W  saturating count of out_valid & !out_ready cycles

Behaviour:
- Reset (rst_n low, takes effect immediately, no clock needed):
  - main_valid = 0, skid_valid = 0.
  - All out_* fields = 0; in_ready = 1; stall_cycles = 0.
  - Reset mid-transfer discards both entries.
- Definitions: accept = in_valid & in_ready; release = out_valid & out_ready.
- States, from (main_valid, skid_valid):
  - EMPTY: accept → ONE, main ← input.
  - ONE:
    - accept & release → ONE, main ← input.
    - accept & !release → TWO, skid ← input.
    - release & !accept → EMPTY.
    - Otherwise hold.
  - TWO: in_ready = 0.
    - release → ONE, main ← skid.
    - Otherwise hold.
  - (0,1) is unreachable; the bench asserts it never occurs.
- Latency and throughput:
  - One cycle from accept to out_valid.
  - Full throughput of 1 instr/cycle while out_ready is held high.
  - in_ready depends only on registered state; there is no combinational in_valid→in_ready or out_ready→in_ready path.
- Flush (synchronous, highest priority):
  - Next edge clears main_valid and skid_valid.
  - An instruction accepted in the flush cycle is discarded, but the handshake still completes from decode's view.
  - Data fields are not cleared.
- Writeback bypass, evaluated every edge when wb_en & wb_rd != 0:
  - Each entry valid after the edge has rs1_data replaced by wb_data if its rs1 == wb_rd; same rule for rs2.
  - This applies to newly captured inputs, held entries, and skid→main moves.
  - wb_rd == 0 never bypasses.
  - A field matching both rs1 and rs2 updates both.
  - Entries being emptied or flushed are not required to update.
- Fields are held while out_valid & !out_ready; out_* must be stable until release.
- While out_valid = 0, out_* fields hold their last value and carry no meaning.
- stall_cycles:
  - +1 each cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W−1.
  - Cleared only by reset; flush does not clear it.

Test Plan:
- Streaming: out_ready=1, inputs pc=0x0,0x4,0x8 on consecutive cycles → out_pc 0x0,0x4,0x8 one cycle later each, in_ready stays 1, stall_cycles=0.
- Backpressure and skid: out_ready=0, send pc=0x10 then 0x14 → in_ready drops to 0 after second accept, out_pc holds 0x10. Release out_ready → out_pc=0x10 then 0x14, in_ready returns to 1, stall_cycles equals the stalled cycles.
- Flush: both entries full, assert flush with in_valid=1 pc=0x20 → next cycle out_valid=0, in_ready=1, and 0x20 never appears.
- Bypass during stall: main holds rs1=5 rs1_data=0x1, rs2=5, out_ready=0; wb_en=1 wb_rd=5 wb_data=0xDEAD → next cycle out_rs1_data=out_rs2_data=0xDEAD. Repeating with wb_rd=0 leaves data unchanged.
- Bypass on capture: in_rs2=7 in_rs2_data=0x3, same cycle wb_rd=7 wb_data=0x99 → out_rs2_data=0x99.
- Reset mid-operation: both entries full, pulse rst_n low between edges → out_valid=0, in_ready=1, out_pc=0, stall_cycles=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// Decode->execute pipeline register: valid/ready handshake with a main+skid
// entry pair, synchronous flush, writeback bypass and a saturating stall counter.
module id_ex_pipe_reg #(
  parameter int XLEN     = 32,
  parameter int RADDR_W  = 5,
  parameter int ALU_OP_W = 4,
  parameter int CTRL_W   = 8,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in_pc,
  input  logic [RADDR_W-1:0]  in_rs1,
  input  logic [RADDR_W-1:0]  in_rs2,
  input  logic [XLEN-1:0]     in_rs1_data,
  input  logic [XLEN-1:0]     in_rs2_data,
  input  logic [XLEN-1:0]     in_imm,
  input  logic [RADDR_W-1:0]  in_rd,
  input  logic [ALU_OP_W-1:0] in_alu_op,
  input  logic [CTRL_W-1:0]   in_ctrl,
  input  logic                flush,
  input  logic                wb_en,
  input  logic [RADDR_W-1:0]  wb_rd,
  input  logic [XLEN-1:0]     wb_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic [RADDR_W-1:0]  out_rs1,
  output logic [RADDR_W-1:0]  out_rs2,
  output logic [XLEN-1:0]     out_rs1_data,
  output logic [XLEN-1:0]     out_rs2_data,
  output logic [XLEN-1:0]     out_imm,
  output logic [RADDR_W-1:0]  out_rd,
  output logic [ALU_OP_W-1:0] out_alu_op,
  output logic [CTRL_W-1:0]   out_ctrl,
  output logic [CNT_W-1:0]    stall_cycles
);

  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [RADDR_W-1:0]  rs1;
    logic [RADDR_W-1:0]  rs2;
    logic [XLEN-1:0]     rs1_data;
    logic [XLEN-1:0]     rs2_data;
    logic [XLEN-1:0]     imm;
    logic [RADDR_W-1:0]  rd;
    logic [ALU_OP_W-1:0] alu_op;
    logic [CTRL_W-1:0]   ctrl;
  } entry_t;

  entry_t main_q, skid_q, in_e, in_b, main_b, skid_b;
  logic main_valid, skid_valid, accept, rel, wb_hit;
  logic [CNT_W-1:0] stall_q;

  // Replace operands that the writeback stage is producing this cycle.
  function automatic entry_t byp(input entry_t e, input logic hit,
                                 input logic [RADDR_W-1:0] rd,
                                 input logic [XLEN-1:0] d);
    entry_t r;
    r = e;
    if (hit && e.rs1 == rd) r.rs1_data = d;
    if (hit && e.rs2 == rd) r.rs2_data = d;
    return r;
  endfunction

  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;
  assign rel      = main_valid && out_ready;
  assign wb_hit   = wb_en && (wb_rd != '0);

  always_comb begin
    in_e          = '0;
    in_e.pc       = in_pc;
    in_e.rs1      = in_rs1;
    in_e.rs2      = in_rs2;
    in_e.rs1_data = in_rs1_data;
    in_e.rs2_data = in_rs2_data;
    in_e.imm      = in_imm;
    in_e.rd       = in_rd;
    in_e.alu_op   = in_alu_op;
    in_e.ctrl     = in_ctrl;
    in_b          = byp(in_e,   wb_hit, wb_rd, wb_data);
    main_b        = byp(main_q, wb_hit, wb_rd, wb_data);
    skid_b        = byp(skid_q, wb_hit, wb_rd, wb_data);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      case ({main_valid, skid_valid})
        2'b00: begin
          if (accept) begin
            main_q     <= in_b;
            main_valid <= 1'b1;
          end
        end
        2'b10: begin
          if (accept && rel) begin
            main_q <= in_b;
          end else if (accept) begin
            main_q     <= main_b;
            skid_q     <= in_b;
            skid_valid <= 1'b1;
          end else if (rel) begin
            main_valid <= 1'b0;
          end else begin
            main_q <= main_b;
          end
        end
        2'b11: begin
          if (rel) begin
            main_q     <= skid_b;
            skid_valid <= 1'b0;
          end else begin
            main_q <= main_b;
            skid_q <= skid_b;
          end
        end
        default: begin
          // skid without main cannot be reached; drop back to empty if it ever is
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_q <= '0;
    else if (main_valid && !out_ready && stall_q != '1)
      stall_q <= stall_q + CNT_W'(1);
  end

  assign out_valid    = main_valid;
  assign out_pc       = main_q.pc;
  assign out_rs1      = main_q.rs1;
  assign out_rs2      = main_q.rs2;
  assign out_rs1_data = main_q.rs1_data;
  assign out_rs2_data = main_q.rs2_data;
  assign out_imm      = main_q.imm;
  assign out_rd       = main_q.rd;
  assign out_alu_op   = main_q.alu_op;
  assign out_ctrl     = main_q.ctrl;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: accepted instructions are queued with
// modelled bypass, popped and compared on every release.
module tb_id_ex_pipe_reg;
  localparam int CNT_W = 4;
  localparam int SAT   = 15;

  logic        clk = 1'b0, rst_n;
  logic        in_valid, in_ready, flush, wb_en, out_valid, out_ready;
  logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm, wb_data;
  logic [4:0]  in_rs1, in_rs2, in_rd, wb_rd;
  logic [3:0]  in_alu_op;
  logic [7:0]  in_ctrl;
  logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [3:0]  out_alu_op;
  logic [7:0]  out_ctrl;
  logic [CNT_W-1:0] stall_cycles;

  id_ex_pipe_reg #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_data(in_rs1_data),
    .in_rs2_data(in_rs2_data), .in_imm(in_imm), .in_rd(in_rd), .in_alu_op(in_alu_op),
    .in_ctrl(in_ctrl), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_imm(out_imm), .out_rd(out_rd), .out_alu_op(out_alu_op), .out_ctrl(out_ctrl),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, rs1_data, rs2_data, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu_op;
    logic [7:0]  ctrl;
  } exp_t;

  exp_t q[$];
  exp_t e, n;
  int total = 0, bad = 0, exp_stall = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] pc, input logic [4:0] r1 = 5'd9,
                      input logic [4:0] r2 = 5'd10,
                      input logic [31:0] d1 = 32'h100, input logic [31:0] d2 = 32'h200);
    in_valid    = 1'b1;
    in_pc       = pc;
    in_rs1      = r1;
    in_rs2      = r2;
    in_rs1_data = d1 + pc;
    in_rs2_data = d2 + pc;
    in_imm      = pc ^ 32'hA5A5;
    in_rd       = pc[6:2];
    in_alu_op   = pc[5:2];
    in_ctrl     = pc[9:2];
  endtask

  // Model evaluated mid-cycle, describing what the coming edge does.
  always @(negedge clk) if (rst_n) begin
    chk("no_skid_only", {63'd0, out_valid | in_ready}, 64'd1);
    if (out_valid && !out_ready && exp_stall != SAT) exp_stall++;
    if (out_valid && out_ready) begin
      chk("sb_expected", {63'd0, q.size() != 0}, 64'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_pc",   out_pc,       e.pc);
        chk("sb_rs1d", out_rs1_data, e.rs1_data);
        chk("sb_rs2d", out_rs2_data, e.rs2_data);
        chk("sb_imm",  out_imm,      e.imm);
        chk("sb_ctl",  {out_rs1, out_rs2, out_rd, out_alu_op, out_ctrl},
                       {e.rs1, e.rs2, e.rd, e.alu_op, e.ctrl});
      end
    end
    if (flush) q.delete();
    else if (in_valid && in_ready) begin
      n.pc = in_pc; n.rs1 = in_rs1; n.rs2 = in_rs2; n.rs1_data = in_rs1_data;
      n.rs2_data = in_rs2_data; n.imm = in_imm; n.rd = in_rd;
      n.alu_op = in_alu_op; n.ctrl = in_ctrl;
      q.push_back(n);
    end
    if (wb_en && wb_rd != 5'd0)
      foreach (q[i]) begin
        if (q[i].rs1 == wb_rd) q[i].rs1_data = wb_data;
        if (q[i].rs2 == wb_rd) q[i].rs2_data = wb_data;
      end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0; wb_rd = '0;
    wb_data = '0; out_ready = 1'b0;
    send(32'h0); in_valid = 1'b0;
    #3;
    chk("rst_valid", out_valid, 0); chk("rst_ready", in_ready, 1);
    chk("rst_pc", out_pc, 0);       chk("rst_stall", stall_cycles, 0);
    #9 rst_n = 1'b1;
    step();

    // streaming
    out_ready = 1'b1;
    send(32'h0); step();
    chk("lat_valid", out_valid, 1); chk("lat_pc", out_pc, 32'h0); chk("str_rdy0", in_ready, 1);
    send(32'h4); step(); chk("str_rdy1", in_ready, 1);
    send(32'h8); step(); chk("str_rdy2", in_ready, 1);
    in_valid = 1'b0; step(); step();
    chk("str_stall", stall_cycles, 0); chk("str_drain", q.size(), 0);

    // backpressure into skid
    out_ready = 1'b0;
    send(32'h10); step(); chk("bp_rdy1", in_ready, 1);
    send(32'h14); step(); in_valid = 1'b0;
    chk("bp_full", in_ready, 0); chk("bp_pc", out_pc, 32'h10);
    step(); step();
    chk("bp_hold", out_pc, 32'h10); chk("bp_stall", stall_cycles, 3);
    out_ready = 1'b1; step();
    chk("bp_pc2", out_pc, 32'h14); chk("bp_rdy2", in_ready, 1);
    step();
    chk("bp_empty", out_valid, 0); chk("bp_drain", q.size(), 0);
    chk("bp_stall2", stall_cycles, exp_stall);

    // flush with both entries full, then flush swallowing an accept
    out_ready = 1'b0;
    send(32'h30); step(); send(32'h34); step();
    send(32'h20); flush = 1'b1; step(); flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", out_valid, 0); chk("fl_ready", in_ready, 1);
    send(32'h40); step();
    send(32'h44); flush = 1'b1; chk("fl_hs", in_ready, 1);
    step(); flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid2", out_valid, 0);
    out_ready = 1'b1; step(); step(); step();
    chk("fl_drain", q.size(), 0);

    // bypass onto a stalled main entry, then wb_rd==0
    out_ready = 1'b0;
    send(32'h50, 5'd5, 5'd5, 32'h1 - 32'h50, 32'h1 - 32'h50); step(); in_valid = 1'b0;
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD; step(); wb_en = 1'b0;
    chk("byp_rs1", out_rs1_data, 32'hDEAD); chk("byp_rs2", out_rs2_data, 32'hDEAD);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    send(32'h54, 5'd0, 5'd0, 32'h11 - 32'h54, 32'h22 - 32'h54); step(); in_valid = 1'b0;
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hBEEF; step(); wb_en = 1'b0;
    chk("byp0_rs1", out_rs1_data, 32'h11); chk("byp0_rs2", out_rs2_data, 32'h22);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // bypass onto held skid entry, checked as it moves to main
    send(32'h58, 5'd1, 5'd3); step();
    send(32'h5c, 5'd2, 5'd2); step(); in_valid = 1'b0;
    wb_en = 1'b1; wb_rd = 5'd2; wb_data = 32'h77; step(); wb_en = 1'b0;
    chk("bypsk_main", out_rs1_data, 32'h158);
    out_ready = 1'b1; step(); step(); out_ready = 1'b0;
    chk("bypsk_drain", q.size(), 0);

    // bypass on capture
    send(32'h60, 5'd6, 5'd7, 32'h5 - 32'h60, 32'h3 - 32'h60);
    wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'h99; step(); in_valid = 1'b0; wb_en = 1'b0;
    chk("bypc_rs2", out_rs2_data, 32'h99); chk("bypc_rs1", out_rs1_data, 32'h5);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // stall counter saturation
    send(32'h70); step(); in_valid = 1'b0;
    repeat (20) step();
    chk("sat", stall_cycles, SAT); chk("sat_model", stall_cycles, exp_stall);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // asynchronous reset with both entries full
    send(32'h80); step(); send(32'h84); step(); in_valid = 1'b0;
    chk("rs_full", in_ready, 0);
    #2 rst_n = 1'b0; #1;
    chk("rs_valid", out_valid, 0); chk("rs_ready", in_ready, 1);
    chk("rs_pc", out_pc, 0);       chk("rs_stall", stall_cycles, 0);
    q.delete(); exp_stall = 0;
    #4 rst_n = 1'b1;
    step(); chk("rs_after", out_valid, 0);
    out_ready = 1'b1; send(32'h90); step();
    chk("rs_pc2", out_pc, 32'h90); in_valid = 1'b0;
    step(); chk("rs_drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
